// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key-entry front end.
// Holds the keypad codes, the operation codes handed to the calculator
// state machine, the key-entry FSM state encoding and the digit/wait limits.
package calc_pkg;

  // Keypad codes (0-9 are plain digits)
  localparam logic [3:0] KEY_9     = 4'd9;
  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_AND   = 4'd12;
  localparam logic [3:0] KEY_ORR   = 4'd13;
  localparam logic [3:0] KEY_EQ    = 4'd14;
  localparam logic [3:0] KEY_CLEAR = 4'd15;

  // Operation codes presented on op_code
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ORR = 3'd3;
  localparam logic [2:0] OP_EQ  = 3'd4;

  localparam int MAX_DIGITS = 4;
  localparam int WAIT_LIMIT = 255;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DIGITS      = 3'd1,
    S_SEND_NUM    = 3'd2,
    S_WAIT_STORE  = 3'd3,
    S_SEND_OP     = 3'd4,
    S_WAIT_RESULT = 3'd5
  } state_e;

  // Operator keys 10..14 map one-to-one onto op codes 0..4.
  function automatic logic [2:0] key_to_op(input logic [3:0] key);
    return 3'(key - KEY_ADD);
  endfunction

endpackage

// File: rtl/bcd_accumulator.sv
// Decimal digit accumulator: next = acc*10 + digit, with a digit count that
// saturates at MAX_DIGITS. Purely combinational; the caller owns the flops.
// Ports:
//   acc_i   current accumulated value
//   cnt_i   digits entered so far
//   digit_i new decimal digit (0-9)
//   acc_o   updated value (unchanged when full)
//   cnt_o   updated digit count (unchanged when full)
//   full_o  high when no further digit may be accepted
module bcd_accumulator
  import calc_pkg::*;
(
  input  logic [15:0] acc_i,
  input  logic [2:0]  cnt_i,
  input  logic [3:0]  digit_i,
  output logic [15:0] acc_o,
  output logic [2:0]  cnt_o,
  output logic        full_o
);

  always_comb begin
    full_o = (cnt_i == 3'(MAX_DIGITS));
    acc_o  = acc_i;
    cnt_o  = cnt_i;
    if (!full_o) begin
      // x*10 as x*8 + x*2; 9999 fits comfortably in 16 bits
      acc_o = (acc_i << 3) + (acc_i << 1) + {12'd0, digit_i};
      cnt_o = cnt_i + 3'd1;
    end
  end

endmodule

// File: rtl/key_entry_sequencer.sv
// Keypad front end for the calculator: collects up to four decimal digits
// into a binary operand, then hands operand and operation to the calculator
// state machine with a pulse/level-acknowledge handshake.
// Handshake: rec_num pulses one cycle with operand valid; operand stays put
// until guardeNum (level) is seen in WAIT_STORE. rec_op pulses one cycle with
// op_code valid. After EQUALS the block waits for leaResult (level) and
// pulses result_ready. Either wait gives up after WAIT_LIMIT cycles.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   key_valid, key_code one-cycle key strobe and code
//   guardeNum, leaResult acknowledges from the calculator
//   rec_num, rec_op     operand / operation strobes
//   operand, op_code    data for the calculator
//   busy                high outside IDLE/DIGITS
//   key_drop            a non-CLEAR key was ignored
//   result_ready        leaResult seen after EQUALS
//   timeout_err         a wait state expired
//   dbg_state           current FSM state
module key_entry_sequencer
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        guardeNum,
  input  logic        leaResult,
  output logic        rec_num,
  output logic        rec_op,
  output logic [15:0] operand,
  output logic [2:0]  op_code,
  output logic        busy,
  output logic        key_drop,
  output logic        result_ready,
  output logic        timeout_err,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_e      state_q, state_d;
  logic [15:0] operand_q, operand_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  wait_q, wait_d;
  logic        rec_num_q, rec_num_d;
  logic        rec_op_q, rec_op_d;
  logic        busy_q, busy_d;
  logic        key_drop_q, key_drop_d;
  logic        result_ready_q, result_ready_d;
  logic        timeout_q, timeout_d;

  logic [15:0] acc_next;
  logic [2:0]  cnt_next;
  logic        acc_full;
  logic        key_clear, key_digit, key_oper, busy_now;

  bcd_accumulator u_acc (
    .acc_i   (operand_q),
    .cnt_i   (cnt_q),
    .digit_i (key_code),
    .acc_o   (acc_next),
    .cnt_o   (cnt_next),
    .full_o  (acc_full)
  );

  always_comb begin
    state_d        = state_q;
    operand_d      = operand_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    wait_d         = wait_q;
    rec_num_d      = 1'b0;
    rec_op_d       = 1'b0;
    key_drop_d     = 1'b0;
    result_ready_d = 1'b0;
    timeout_d      = 1'b0;

    key_clear = key_valid && (key_code == KEY_CLEAR);
    key_digit = key_valid && (key_code <= KEY_9);
    key_oper  = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_EQ);
    busy_now  = !((state_q == S_IDLE) || (state_q == S_DIGITS));

    if (key_clear) begin
      // CLEAR wins over everything, including an acknowledge this cycle
      state_d   = S_IDLE;
      operand_d = '0;
      cnt_d     = '0;
      op_d      = '0;
      wait_d    = '0;
    end else begin
      if (key_valid && busy_now) key_drop_d = 1'b1;
      unique case (state_q)
        S_IDLE, S_DIGITS: begin
          if (key_digit) begin
            if (acc_full) begin
              key_drop_d = 1'b1;
            end else begin
              operand_d = acc_next;
              cnt_d     = cnt_next;
              state_d   = S_DIGITS;
            end
          end else if (key_oper) begin
            op_d = key_to_op(key_code);
            if (state_q == S_DIGITS) begin
              state_d   = S_SEND_NUM;
              rec_num_d = 1'b1;
            end else begin
              // No digits typed: chain on the calculator's previous result
              state_d  = S_SEND_OP;
              rec_op_d = 1'b1;
            end
          end
        end
        S_SEND_NUM: begin
          state_d = S_WAIT_STORE;
          wait_d  = '0;
        end
        S_WAIT_STORE: begin
          if (guardeNum) begin
            state_d  = S_SEND_OP;
            rec_op_d = 1'b1;
          end else if (wait_q == WAIT_LAST) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
            operand_d = '0;
            cnt_d     = '0;
            wait_d    = '0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        S_SEND_OP: begin
          operand_d = '0;
          cnt_d     = '0;
          wait_d    = '0;
          state_d   = (op_q == OP_EQ) ? S_WAIT_RESULT : S_IDLE;
        end
        S_WAIT_RESULT: begin
          if (leaResult) begin
            state_d        = S_IDLE;
            result_ready_d = 1'b1;
          end else if (wait_q == WAIT_LAST) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
            operand_d = '0;
            cnt_d     = '0;
            wait_d    = '0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = !((state_d == S_IDLE) || (state_d == S_DIGITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      operand_q      <= '0;
      cnt_q          <= '0;
      op_q           <= '0;
      wait_q         <= '0;
      rec_num_q      <= 1'b0;
      rec_op_q       <= 1'b0;
      busy_q         <= 1'b0;
      key_drop_q     <= 1'b0;
      result_ready_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      operand_q      <= operand_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      wait_q         <= wait_d;
      rec_num_q      <= rec_num_d;
      rec_op_q       <= rec_op_d;
      busy_q         <= busy_d;
      key_drop_q     <= key_drop_d;
      result_ready_q <= result_ready_d;
      timeout_q      <= timeout_d;
    end
  end

  assign rec_num      = rec_num_q;
  assign rec_op       = rec_op_q;
  assign operand      = operand_q;
  assign op_code      = op_q;
  assign busy         = busy_q;
  assign key_drop     = key_drop_q;
  assign result_ready = result_ready_q;
  assign timeout_err  = timeout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Bench for key_entry_sequencer: a per-cycle vector table for the basic
// entry/send flow, hand-written sequences for the multi-cycle corners, and
// an event scoreboard that checks every output pulse in order.
module tb_key_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        guardeNum;
  logic        leaResult;
  logic        rec_num, rec_op, busy, key_drop, result_ready, timeout_err;
  logic [15:0] operand;
  logic [2:0]  op_code;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse events: {rec_num, rec_op, key_drop, result_ready, timeout_err, operand, op_code}
  logic [23:0] exp_q[$];

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        g;
    logic        l;
    logic        busy;
    logic        rn;
    logic        ro;
    logic        kd;
    logic [15:0] opnd;
    logic [2:0]  op;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[18];

  key_entry_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .guardeNum    (guardeNum),
    .leaResult    (leaResult),
    .rec_num      (rec_num),
    .rec_op       (rec_op),
    .operand      (operand),
    .op_code      (op_code),
    .busy         (busy),
    .key_drop     (key_drop),
    .result_ready (result_ready),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic kv, input logic [3:0] kc, input logic g, input logic l);
    key_valid = kv;
    key_code  = kc;
    guardeNum = g;
    leaResult = l;
  endtask

  task automatic push_ev(input logic rn, input logic ro, input logic kd, input logic rr,
                         input logic to, input logic [15:0] opnd, input logic [2:0] op);
    exp_q.push_back({rn, ro, kd, rr, to, opnd, op});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int kv, input int kc, input int g, input int l,
                              input int b, input int rn, input int ro, input int kd,
                              input int opnd, input int op, input int st);
    vec_t v;
    v.kv = kv[0]; v.kc = kc[3:0]; v.g = g[0]; v.l = l[0];
    v.busy = b[0]; v.rn = rn[0]; v.ro = ro[0]; v.kd = kd[0];
    v.opnd = opnd[15:0]; v.op = op[2:0]; v.st = st[2:0];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [23:0] obs;
    logic [23:0] exp;
    if (rst_n && (rec_num || rec_op || key_drop || result_ready || timeout_err)) begin
      obs = {rec_num, rec_op, key_drop, result_ready, timeout_err, operand, op_code};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: act=0x%06h req=no pulse", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL sb_event: act=0x%06h req=0x%06h", obs, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // state codes: 0 IDLE, 1 DIGITS, 2 SEND_NUM, 3 WAIT_STORE, 4 SEND_OP, 5 WAIT_RESULT
    //               kv kc  g  l  busy rn ro kd operand op st
    vecs[0]  = mk(1, 1,  0, 0, 0, 0, 0, 0, 1,    0, 1);
    vecs[1]  = mk(1, 2,  0, 0, 0, 0, 0, 0, 12,   0, 1);
    vecs[2]  = mk(1, 3,  0, 0, 0, 0, 0, 0, 123,  0, 1);
    vecs[3]  = mk(1, 10, 0, 0, 1, 1, 0, 0, 123,  0, 2);
    vecs[4]  = mk(0, 0,  0, 0, 1, 0, 0, 0, 123,  0, 3);
    vecs[5]  = mk(0, 0,  0, 0, 1, 0, 0, 0, 123,  0, 3);
    vecs[6]  = mk(0, 0,  1, 0, 1, 0, 1, 0, 123,  0, 4);
    vecs[7]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0,    0, 0);
    vecs[8]  = mk(1, 11, 0, 0, 1, 0, 1, 0, 0,    1, 4);
    vecs[9]  = mk(1, 5,  0, 0, 0, 0, 0, 1, 0,    1, 0);
    vecs[10] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0,    1, 0);
    vecs[11] = mk(1, 9,  0, 0, 0, 0, 0, 0, 9,    1, 1);
    vecs[12] = mk(1, 9,  0, 0, 0, 0, 0, 0, 99,   1, 1);
    vecs[13] = mk(1, 9,  0, 0, 0, 0, 0, 0, 999,  1, 1);
    vecs[14] = mk(1, 9,  0, 0, 0, 0, 0, 0, 9999, 1, 1);
    vecs[15] = mk(1, 5,  0, 0, 0, 0, 0, 1, 9999, 1, 1);
    vecs[16] = mk(0, 0,  0, 0, 0, 0, 0, 0, 9999, 1, 1);
    vecs[17] = mk(1, 15, 0, 0, 0, 0, 0, 0, 0,    0, 0);

    // Reset
    rst_n = 1'b0;
    drive(0, 4'd0, 0, 0);
    repeat (3) step();
    check("reset_outputs",
          64'({rec_num, rec_op, busy, key_drop, result_ready, timeout_err, operand, op_code, dbg_state}),
          64'd0);
    rst_n = 1'b1;

    // Table: digit entry, send, chaining operator, busy drop, saturation, CLEAR
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].kv, vecs[i].kc, vecs[i].g, vecs[i].l);
      if (vecs[i].rn || vecs[i].ro || vecs[i].kd)
        push_ev(vecs[i].rn, vecs[i].ro, vecs[i].kd, 1'b0, 1'b0, vecs[i].opnd, vecs[i].op);
      step();
      check($sformatf("vec%0d", i),
            64'({busy, rec_num, rec_op, key_drop, operand, op_code, dbg_state}),
            64'({vecs[i].busy, vecs[i].rn, vecs[i].ro, vecs[i].kd, vecs[i].opnd, vecs[i].op, vecs[i].st}));
    end
    drive(0, 4'd0, 0, 0);
    step();
    check("table_queue_empty", 64'(exp_q.size()), 64'd0);

    // Key 7, EQUALS, store ack, result after 10 cycles
    drive(1, 4'd7, 0, 0); step();
    drive(1, 4'd14, 0, 0); push_ev(1, 0, 0, 0, 0, 16'd7, 3'd4); step();
    check("eq_rec_num", 64'({rec_num, operand}), 64'({1'b1, 16'd7}));
    drive(0, 4'd0, 0, 0); step();
    drive(0, 4'd0, 1, 0); push_ev(0, 1, 0, 0, 0, 16'd7, 3'd4); step();
    check("eq_rec_op", 64'({rec_op, rec_num, op_code}), 64'({1'b1, 1'b0, 3'd4}));
    drive(0, 4'd0, 0, 0); step();
    check("eq_wait_result", 64'({dbg_state, busy, operand}), 64'({3'd5, 1'b1, 16'd0}));
    for (int i = 0; i < 9; i++) step();
    drive(0, 4'd0, 0, 1); push_ev(0, 0, 0, 1, 0, 16'd0, 3'd4); step();
    check("eq_result_ready", 64'({result_ready, dbg_state}), 64'({1'b1, 3'd0}));
    drive(0, 4'd0, 0, 0); step();
    check("eq_result_ready_once", 64'(result_ready), 64'd0);
    check("eq_queue_empty", 64'(exp_q.size()), 64'd0);

    // Key 4, SUB, no store ack: timeout
    drive(1, 4'd4, 0, 0); step();
    drive(1, 4'd11, 0, 0); push_ev(1, 0, 0, 0, 0, 16'd4, 3'd1); step();
    drive(0, 4'd0, 0, 0); step();
    check("to_in_wait_store", 64'(dbg_state), 64'd3);
    push_ev(0, 0, 0, 0, 1, 16'd0, 3'd1);
    begin
      int seen;
      seen = 0;
      for (int n = 1; n <= 300; n++) begin
        step();
        if (timeout_err) begin
          seen = n;
          break;
        end
      end
      check("to_cycle", 64'(seen), 64'd255);
    end
    check("to_after", 64'({dbg_state, operand, busy}), 64'd0);
    step();
    check("to_queue_empty", 64'(exp_q.size()), 64'd0);

    // CLEAR in the same cycle as the store ack
    drive(1, 4'd6, 0, 0); step();
    drive(1, 4'd10, 0, 0); push_ev(1, 0, 0, 0, 0, 16'd6, 3'd0); step();
    drive(0, 4'd0, 0, 0); step();
    drive(1, 4'd15, 1, 0); step();
    check("clr_ack", 64'({dbg_state, operand, op_code, rec_op, busy}), 64'd0);
    drive(0, 4'd0, 0, 0);
    step(); step();
    check("clr_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset during WAIT_RESULT
    drive(1, 4'd3, 0, 0); step();
    drive(1, 4'd14, 0, 0); push_ev(1, 0, 0, 0, 0, 16'd3, 3'd4); step();
    drive(0, 4'd0, 0, 0); step();
    drive(0, 4'd0, 1, 0); push_ev(0, 1, 0, 0, 0, 16'd3, 3'd4); step();
    drive(0, 4'd0, 0, 0); step();
    step(); step();
    check("rst_in_wait_result", 64'(dbg_state), 64'd5);
    rst_n = 1'b0;
    #2;
    check("rst_async_outputs",
          64'({rec_num, rec_op, busy, key_drop, result_ready, timeout_err, operand, op_code, dbg_state}),
          64'd0);
    drive(0, 4'd0, 0, 1);
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    check("rst_release_idle", 64'({dbg_state, result_ready, busy}), 64'd0);
    drive(1, 4'd8, 0, 0); step();
    check("rst_resume", 64'({dbg_state, operand}), 64'({3'd1, 16'd8}));
    drive(0, 4'd0, 0, 0); step();
    check("rst_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_entry_sequencer.md
KEY_ENTRY_SEQUENCER -- requirements
Module: key_entry_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe; key_code is valid on this cycle.
- key_code  in  4  0-9 digit, 10 ADD, 11 SUB, 12 AND, 13 ORR, 14 EQUALS, 15 CLEAR.
- guardeNum  in  1  level from the calculator state machine: number stored (acknowledge for rec_num).
- leaResult  in  1  level from the calculator state machine: result ready to read (acknowledge for EQUALS).
- rec_num  out  1  one-cycle pulse: operand is valid for the calculator.
- rec_op  out  1  one-cycle pulse: op_code is valid for the calculator.
- operand  out  16  accumulated binary operand; stable from the rec_num pulse until the guardeNum acknowledge.
- op_code  out  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EQ; stable during the rec_op pulse.
- busy  out  1  high in any state other than IDLE/DIGITS.
- key_drop  out  1  one-cycle pulse when a non-CLEAR key is ignored.
- result_ready  out  1  one-cycle pulse when leaResult is seen after EQUALS.
- timeout_err  out  1  one-cycle pulse when a wait state expires.

Function
REQ-002 The FSM SHALL have the states IDLE, DIGITS, SEND_NUM, WAIT_STORE, SEND_OP and WAIT_RESULT.
REQ-003 A digit key in IDLE/DIGITS SHALL update operand <= operand*10 + digit and increment digit_cnt, then go to DIGITS.
REQ-004 When digit_cnt = 4, further digits SHALL be ignored and SHALL pulse key_drop; the maximum operand is 9999.
REQ-005 An operator key (10-14) in DIGITS SHALL latch op_code and go to SEND_NUM; rec_num SHALL pulse on the cycle after key acceptance.
REQ-006 An operator key (10-14) in IDLE (no digits) SHALL latch op_code and go directly to SEND_OP, which chains on the previous result.
REQ-007 SEND_NUM SHALL last exactly one cycle and then go to WAIT_STORE.
REQ-008 WAIT_STORE SHALL exit to SEND_OP on the first cycle guardeNum = 1; rec_op SHALL pulse in the following cycle.
REQ-009 SEND_OP SHALL last one cycle; on exit, operand and digit_cnt SHALL clear to 0.
REQ-010 After SEND_OP, the FSM SHALL go to WAIT_RESULT if op_code = EQ, and to IDLE otherwise.
REQ-011 WAIT_RESULT SHALL go to IDLE and pulse result_ready on the first cycle leaResult = 1.
REQ-012 An 8-bit wait counter SHALL clear on entry to WAIT_STORE and WAIT_RESULT.
- After 255 cycles without the acknowledge: timeout_err pulse, operand/digit_cnt clear, go to IDLE.
REQ-013 CLEAR in any state SHALL go to IDLE, zero operand/digit_cnt/op_code/wait counter, and emit no rec_num/rec_op.
REQ-014 CLEAR SHALL take priority over a guardeNum or leaResult acknowledge in the same cycle.
REQ-015 Non-CLEAR keys while busy = 1 SHALL be ignored with a key_drop pulse; at most one key is accepted per cycle.
REQ-016 rec_num and rec_op SHALL never be high in the same cycle, and every output SHALL come from a register.

Reset
REQ-017 While rst_n = 0, the following SHALL be held:
- state = IDLE;
- operand, op_code, digit_cnt and the wait counter = 0;
- rec_num, rec_op, busy, key_drop, result_ready and timeout_err = 0.
REQ-018 Reset asserted mid-handshake SHALL abandon the transaction with no pulse on release; operation resumes on the first clock edge after rst_n rises.

Structure
REQ-019 A shared package calc_pkg SHALL hold:
- the key-code constants;
- the op-code constants;
- the FSM state encoding;
- MAX_DIGITS = 4 and WAIT_LIMIT = 255.
REQ-020 The digit arithmetic (x*10 + d, saturating at digit_cnt = 4) SHALL be one sub-module, bcd_accumulator; the FSM and wait counter SHALL stay in key_entry_sequencer.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios.
- Keys 1,2,3 then ADD, guardeNum high 3 cycles later -> operand = 123 at the rec_num pulse; rec_op pulses the cycle after guardeNum with op_code = 0; state returns to IDLE.
- Keys 9,9,9,9,5 -> operand = 9999; key_drop pulses once, on the fifth key.
- Key 7, EQUALS, guardeNum, leaResult after 10 cycles -> rec_num, rec_op (op_code = 4), then one result_ready pulse.
- Key 4, SUB, guardeNum held 0 -> timeout_err 255 cycles after entering WAIT_STORE; no rec_op; operand = 0.
- SUB in IDLE -> rec_op with op_code = 1 and no rec_num; a key during busy -> key_drop.
- CLEAR in the same cycle as guardeNum -> IDLE, no rec_op.
- rst_n pulsed low during WAIT_RESULT -> all outputs 0; no result_ready after release.
